// File: rtl/mult_serial_pkg.sv
// Shared types and constants for the serial multiplier host.
// The state encoding is fixed at 3 bits so it can be probed and compared directly.
package mult_serial_pkg;

    localparam int OPERAND_BITS  = 8;
    localparam int PRODUCT_BITS  = 8;
    localparam int RESP_WAIT_MAX = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RECV  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/ser_shift8.sv
// 8-bit load / shift-right register.
// Transmit use: load the operands, then emit q[0]. Receive use: shift the serial line in at bit 7.
module ser_shift8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    input  logic       shift_in,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 8'h00;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {shift_in, q[7:1]};
        end
    end

endmodule

// File: rtl/mult_serial_host.sv
// Host side of a bit-serial 4x4 multiplier link: sends {b,a} LSB first after a start pulse,
// waits RESP_WAIT clocks, then collects the 8-bit product LSB first.
//
// state | meaning
// IDLE  | ready for a request; operands latched on req_valid
// START | start strobe is generated for the next cycle
// SEND  | 8 operand bits are shifted out
// WAIT  | RESP_WAIT turnaround clocks (skipped when RESP_WAIT is 0)
// RECV  | 8 product bits are sampled from ser_in
// DONE  | product is published and rsp_valid is pulsed
module mult_serial_host
    import mult_serial_pkg::*;
#(
    parameter int RESP_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       start,
    output logic       ser_out,
    input  logic       ser_in,
    output logic       rsp_valid,
    output logic [7:0] rsp_prod,
    output logic       busy
);

    localparam logic [3:0] WAIT_LOAD = (RESP_WAIT > 0) ? 4'(RESP_WAIT - 1) : 4'd0;

    state_t     state;
    state_t     next_state;
    logic [2:0] bit_cnt;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       load_bits;
    logic       load_wait;
    logic       tx_shift;
    logic       rx_shift;
    logic       start_d;
    logic       ser_out_d;
    logic       rsp_valid_d;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic       unused_tx_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (req_valid) next_state = ST_START;
            ST_START: next_state = ST_SEND;
            ST_SEND:  if (bit_cnt == 3'd0) next_state = (RESP_WAIT == 0) ? ST_RECV : ST_WAIT;
            ST_WAIT:  if (wait_cnt == 4'd0) next_state = ST_RECV;
            ST_RECV:  if (bit_cnt == 3'd0) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == ST_IDLE);
        busy        = (state != ST_IDLE);
        accept      = (state == ST_IDLE) && req_valid;
        tx_shift    = (state == ST_SEND);
        rx_shift    = (state == ST_RECV);
        start_d     = (state == ST_START);
        ser_out_d   = (state == ST_SEND) && tx_q[0];
        rsp_valid_d = (state == ST_DONE);
        load_bits   = (next_state != state) && ((next_state == ST_SEND) || (next_state == ST_RECV));
        load_wait   = (next_state == ST_WAIT) && (state != ST_WAIT);
    end

    // Down-counters are reloaded on state entry and stick at zero, so exit always sees a clean count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            wait_cnt <= 4'd0;
        end else begin
            if (load_bits) begin
                bit_cnt <= 3'd7;
            end else if (bit_cnt != 3'd0) begin
                bit_cnt <= bit_cnt - 3'd1;
            end
            if (load_wait) begin
                wait_cnt <= WAIT_LOAD;
            end else if (wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start     <= 1'b0;
            ser_out   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_prod  <= 8'h00;
        end else begin
            start     <= start_d;
            ser_out   <= ser_out_d;
            rsp_valid <= rsp_valid_d;
            if (rsp_valid_d) begin
                rsp_prod <= rx_q;
            end
        end
    end

    ser_shift8 u_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data ({b, a}),
        .shift     (tx_shift),
        .shift_in  (1'b0),
        .q         (tx_q)
    );

    // Cleared on accept so a frame aborted mid-receive never leaks stale bits.
    ser_shift8 u_rx (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (8'h00),
        .shift     (rx_shift),
        .shift_in  (ser_in),
        .q         (rx_q)
    );

    assign unused_tx_hi = ^tx_q[7:1];

endmodule

// File: tb/tb_mult_serial_host.sv
// Directed bench for mult_serial_host with a behavioural serial multiplier on the far end.
// Three builds (RESP_WAIT 2, 0, 15) share the bus; sel picks the one being exercised.
module tb_mult_serial_host;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       ser_in;
    logic [1:0] sel;

    logic [2:0] start_v;
    logic [2:0] ser_out_v;
    logic [2:0] rsp_valid_v;
    logic [2:0] busy_v;
    logic [2:0] ready_v;
    logic [7:0] prod_v [3];

    logic       start_m;
    logic       ser_out_m;
    logic       rsp_valid_m;
    logic       busy_m;
    logic       ready_m;
    logic [7:0] prod_m;

    logic [7:0] cap_v;
    int         total;
    int         bad;

    assign start_m     = start_v[sel];
    assign ser_out_m   = ser_out_v[sel];
    assign rsp_valid_m = rsp_valid_v[sel];
    assign busy_m      = busy_v[sel];
    assign ready_m     = ready_v[sel];
    assign prod_m      = prod_v[sel];

    mult_serial_host #(.RESP_WAIT(2)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid && (sel == 2'd0)), .req_ready(ready_v[0]),
        .a(a), .b(b), .start(start_v[0]), .ser_out(ser_out_v[0]), .ser_in(ser_in),
        .rsp_valid(rsp_valid_v[0]), .rsp_prod(prod_v[0]), .busy(busy_v[0])
    );

    mult_serial_host #(.RESP_WAIT(0)) u_dut_w0 (
        .clk(clk), .reset(reset), .req_valid(req_valid && (sel == 2'd1)), .req_ready(ready_v[1]),
        .a(a), .b(b), .start(start_v[1]), .ser_out(ser_out_v[1]), .ser_in(ser_in),
        .rsp_valid(rsp_valid_v[1]), .rsp_prod(prod_v[1]), .busy(busy_v[1])
    );

    mult_serial_host #(.RESP_WAIT(15)) u_dut_w15 (
        .clk(clk), .reset(reset), .req_valid(req_valid && (sel == 2'd2)), .req_ready(ready_v[2]),
        .a(a), .b(b), .start(start_v[2]), .ser_out(ser_out_v[2]), .ser_in(ser_in),
        .rsp_valid(rsp_valid_v[2]), .rsp_prod(prod_v[2]), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int w_of(input logic [1:0] s);
        if (s == 2'd1) return 0;
        if (s == 2'd2) return 15;
        return 2;
    endfunction

    // Far-end multiplier: collect the 8 operand bits after start, wait, return the product LSB first.
    // ser_in is X whenever the product is not being driven.
    initial begin
        logic [7:0] c;
        logic [7:0] p;
        bit         abort;
        int         w;
        ser_in = 1'bx;
        cap_v  = 8'h00;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || start_m !== 1'b1) continue;
            w     = w_of(sel);
            abort = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (reset !== 1'b0) abort = 1'b1;
                c[i] = ser_out_m;
            end
            if (abort) continue;
            cap_v = c;
            p = {4'b0, c[3:0]} * {4'b0, c[7:4]};
            repeat (w) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                ser_in = p[i];
                @(negedge clk);
            end
            ser_in = 1'bx;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request; a/b are overwritten with na/nb right after the accept edge.
    task automatic do_frame(input string tag, input logic [3:0] ta, input logic [3:0] tbv,
                            input logic [3:0] na, input logic [3:0] nb,
                            input bit hold, input logic [7:0] exp);
        int got;
        int extra;
        got   = -1;
        extra = 0;
        @(negedge clk);
        chk({tag, "_ready"}, ready_m, 1);
        a = ta;
        b = tbv;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        a = na;
        b = nb;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk({tag, "_start"}, start_m, 1);
                chk({tag, "_start_ser0"}, ser_out_m, 0);
            end
            if (n >= 2 && start_m === 1'b1) extra++;
            if (rsp_valid_m === 1'b1) begin
                got = n;
                break;
            end
        end
        chk({tag, "_latency"}, got, 18 + w_of(sel));
        chk({tag, "_prod"}, prod_m, exp);
        chk({tag, "_operand_bits"}, cap_v, {tbv, ta});
        chk({tag, "_no_restart"}, extra, 0);
        chk({tag, "_ready_after"}, ready_m, 1);
        @(negedge clk);
        chk({tag, "_pulse"}, rsp_valid_m, 0);
    endtask

    initial begin
        int got;
        int seen;
        total     = 0;
        bad       = 0;
        sel       = 2'd0;
        reset     = 1'b1;
        req_valid = 1'b0;
        a         = 4'h0;
        b         = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_start", start_m, 0);
        chk("rst_ser_out", ser_out_m, 0);
        chk("rst_rsp_valid", rsp_valid_m, 0);
        chk("rst_prod", prod_m, 0);
        chk("rst_busy", busy_m, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_ready", ready_m, 1);
        chk("rel_busy", busy_m, 0);

        do_frame("m3x5", 4'd3, 4'd5, 4'd12, 4'd10, 1'b0, 8'h0F);
        do_frame("m15x15", 4'd15, 4'd15, 4'd0, 4'd0, 1'b0, 8'hE1);
        do_frame("m0x9", 4'd0, 4'd9, 4'd15, 4'd6, 1'b0, 8'h00);

        // req_valid stays high: the frame keeps 3x5, then the held 6x7 is taken after DONE.
        do_frame("hold1", 4'd3, 4'd5, 4'd6, 4'd7, 1'b1, 8'h0F);
        req_valid = 1'b0;
        got = -1;
        for (int n = 1; n < 70; n++) begin
            @(negedge clk);
            if (rsp_valid_m === 1'b1) begin
                got = n;
                break;
            end
        end
        chk("hold2_latency", got, 20);
        chk("hold2_prod", prod_m, 8'h2A);
        chk("hold2_operand_bits", cap_v, 8'h76);
        repeat (3) @(negedge clk);

        // Reset while the 4th operand bit (a[3]=1) is on the line.
        a = 4'd9;
        b = 4'd7;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_bit4", ser_out_m, 1);
        reset = 1'b1;
        #1;
        chk("abort_start", start_m, 0);
        chk("abort_ser_out", ser_out_m, 0);
        chk("abort_rsp_valid", rsp_valid_m, 0);
        chk("abort_prod", prod_m, 0);
        chk("abort_busy", busy_m, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsp_valid_m !== 1'b0) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        do_frame("after_abort", 4'd9, 4'd7, 4'd1, 4'd1, 1'b0, 8'h3F);

        sel = 2'd1;
        repeat (2) @(negedge clk);
        do_frame("w0_7x9", 4'd7, 4'd9, 4'd3, 4'd3, 1'b0, 8'h3F);

        sel = 2'd2;
        repeat (2) @(negedge clk);
        do_frame("w15_7x9", 4'd7, 4'd9, 4'd2, 4'd5, 1'b0, 8'h3F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
